// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
// Shared types, constants and the round-robin search helper used by the
// FIFO write arbiter and its picker.
//   arb_state_e : arbiter FSM states (ARB_IDLE, ARB_GRANT)
//   STATS_W     : width of the optional accepted-beat counter
//   MAX_REQ     : largest supported producer count
//   next_rr()   : index of the first set request bit at or after ptr,
//                 wrapping modulo num_req (returns ptr when nothing is set)
package fifo_arb_pkg;

    localparam int STATS_W = 16;
    localparam int MAX_REQ = 16;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Linear scan starting at ptr. The index is wrapped by a single
    // subtraction because ptr and the offset are both below num_req.
    function automatic int next_rr(input logic [MAX_REQ-1:0] req,
                                   input int                 ptr,
                                   input int                 num_req);
        int   idx;
        int   win;
        logic found;
        win   = ptr;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = ptr + i;
            if (idx >= num_req) begin
                idx = idx - num_req;
            end
            if (!found && (i < num_req) && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker
// Combinational round-robin selector.
//   req_i   [NUM_REQ-1:0] : request vector, bit k is producer k
//   ptr_i   [OW-1:0]      : highest-priority index for this decision
//   valid_o               : at least one request is set
//   idx_o   [OW-1:0]      : winning index (only meaningful when valid_o)
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int OW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [OW-1:0]      ptr_i,
    output logic               valid_o,
    output logic [OW-1:0]      idx_o
);

    logic [MAX_REQ-1:0] req_ext;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req_i;
        valid_o                = |req_i;
        idx_o                  = OW'(next_rr(req_ext, int'(ptr_i), NUM_REQ));
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter sharing one synchronous FIFO write port between
// NUM_REQ producers. The winner owns the port for a burst of up to
// MAX_BURST beats; the FIFO full flag gates every beat combinationally.
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   req_i             : per-producer request
//   req_data_i        : flattened producer data, producer k at
//                       [k*DATA_WIDTH +: DATA_WIDTH]
//   gnt_o             : one-hot beat acknowledge
//   fifo_full         : FIFO full flag
//   fifo_wr_en        : FIFO write enable
//   fifo_data_o       : FIFO write data
//   busy_o            : high while a producer owns the port
//   wr_count_o        : saturating count of accepted beats, present only
//                       when FIFO_ARB_STATS_EN is defined
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_o,
    output logic                          busy_o
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0]            wr_count_o
`endif
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
    localparam logic [OW-1:0] LAST_IDX  = OW'(NUM_REQ - 1);

    arb_state_e    state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] ptr_q,   ptr_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    logic          pick_valid;
    logic [OW-1:0] pick_idx;
    logic          owner_req;
    logic          beat;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .OW      (OW)
    ) u_picker (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // Beat path: decoded from the owner register with a loop rather than a
    // variable part-select, so a non-power-of-two NUM_REQ never indexes
    // past the data bus. Only the owner can ever see a grant.
    always_comb begin
        gnt_o       = '0;
        fifo_data_o = '0;
        owner_req   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (owner_q == OW'(k)) begin
                owner_req = req_i[k];
                if (state_q == ARB_GRANT) begin
                    gnt_o[k]    = req_i[k] & ~fifo_full;
                    fifo_data_o = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
        fifo_wr_en = |gnt_o;
        beat       = fifo_wr_en;
    end

    // Next-state logic. A full FIFO only stalls the counter; the burst ends
    // when the owner withdraws or its last permitted beat is accepted.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (!owner_req || (beat && (cnt_q == LAST_BEAT))) begin
                    state_d = ARB_IDLE;
                    ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + OW'(1);
                    cnt_d   = '0;
                end else if (beat) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o = (state_q == ARB_GRANT);

`ifdef FIFO_ARB_STATS_EN
    logic [STATS_W-1:0] wr_count_q, wr_count_d;

    // Saturates at all-ones instead of wrapping.
    always_comb begin
        wr_count_d = wr_count_q;
        if (beat && (wr_count_q != '1)) begin
            wr_count_d = wr_count_q + STATS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
        end
    end

    assign wr_count_o = wr_count_q;
`endif

endmodule
